// File: rtl/pds_cycle_ctl_pkg.sv
// Shared state encoding and default sizing for the PDS cycle controller.
package pds_cycle_pkg;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EDGE,
    STROBE,
    ACK,
    VPA_HOLD,
    BERR,
    RELEASE
  } state_t;

endpackage

// File: rtl/pds_cycle_ctl_if.sv
// CPU-side and PDS-side signals of one 68030-to-SE PDS cycle; slave is the controller's view.
interface pds_cycle_ctl_if;

  logic       ncpuAS;
  logic       cpuRnW;
  logic [2:0] cpuFC;
  logic       pdsSel;
  logic       pdsC8m;
  logic       npdsDtack;
  logic       npdsVpa;
  logic       npdsAs;
  logic       cycleActive;
  logic       dsackReq;
  logic       vpaCycle;
  logic       berrReq;
  logic       timeoutFlag;

  modport master (
    output ncpuAS, cpuRnW, cpuFC, pdsSel, pdsC8m, npdsDtack, npdsVpa,
    input  npdsAs, cycleActive, dsackReq, vpaCycle, berrReq, timeoutFlag
  );

  modport slave (
    input  ncpuAS, cpuRnW, cpuFC, pdsSel, pdsC8m, npdsDtack, npdsVpa,
    output npdsAs, cycleActive, dsackReq, vpaCycle, berrReq, timeoutFlag
  );

endinterface

// File: rtl/pds_cycle_ctl_sync.sv
// Multi-flop synchronizer into cpuClock; presets high so the active-low PDS lines read negated in reset.
module pds_sync #(
  parameter int STAGES = 2
) (
  input  logic cpuClock,
  input  logic npdsReset,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], async_in};

  always_ff @(posedge cpuClock or negedge npdsReset) begin
    if (!npdsReset) sync_q <= '1;
    else            sync_q <= sync_d;
  end

  assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/pds_cycle_ctl.sv
// Runs a 68030 cycle on the SE PDS bus: AS aligned to C8m fall, DTACK/VPA termination, timeout bus error.
// Outputs are registered from next state; DTACK reaches dsackReq SYNC_STAGES+1 edges after setup.
module pds_cycle_ctl
  import pds_cycle_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic          cpuClock,
  input  logic          npdsReset,
  pds_cycle_ctl_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic dtack_s, vpa_s, c8m_s, c8m_fall;
  logic unused_rnw;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          c8m_prev_q, c8m_prev_d;
  logic          npds_as_q, npds_as_d;
  logic          cycle_active_q, cycle_active_d;
  logic          dsack_req_q, dsack_req_d;
  logic          vpa_cycle_q, vpa_cycle_d;
  logic          berr_req_q, berr_req_d;
  logic          timeout_flag_q, timeout_flag_d;

  pds_sync #(.STAGES(SYNC_STAGES)) u_sync_dtack (
    .cpuClock(cpuClock), .npdsReset(npdsReset), .async_in(bus.npdsDtack), .sync_out(dtack_s));
  pds_sync #(.STAGES(SYNC_STAGES)) u_sync_vpa (
    .cpuClock(cpuClock), .npdsReset(npdsReset), .async_in(bus.npdsVpa), .sync_out(vpa_s));
  pds_sync #(.STAGES(SYNC_STAGES)) u_sync_c8m (
    .cpuClock(cpuClock), .npdsReset(npdsReset), .async_in(bus.pdsC8m), .sync_out(c8m_s));

  // Bus direction does not affect PDS sequencing.
  assign unused_rnw = bus.cpuRnW;
  assign c8m_fall   = c8m_prev_q & ~c8m_s;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    c8m_prev_d = c8m_s;
    unique case (state_q)
      IDLE:      if (!bus.ncpuAS && bus.pdsSel && bus.cpuFC != 3'd7) state_d = WAIT_EDGE;
      WAIT_EDGE: if (bus.ncpuAS) state_d = RELEASE;
                 else if (c8m_fall) state_d = STROBE;
      STROBE: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        if (bus.ncpuAS)          state_d = RELEASE;
        else if (!dtack_s)       state_d = ACK;
        else if (!vpa_s)         state_d = VPA_HOLD;
        else if (cnt_q >= CNT_LAST) state_d = BERR;
      end
      ACK:            state_d = RELEASE;
      VPA_HOLD, BERR: if (bus.ncpuAS) state_d = RELEASE;
      RELEASE: begin
        if (bus.ncpuAS && dtack_s && vpa_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // AS stays low through the ACK cycle and negates on entry to RELEASE.
    npds_as_d      = !(state_d == STROBE || state_d == ACK || state_d == VPA_HOLD || state_d == BERR);
    cycle_active_d = (state_d != IDLE);
    dsack_req_d    = (state_d == ACK);
    vpa_cycle_d    = (state_d == VPA_HOLD);
    berr_req_d     = (state_d == BERR);
    timeout_flag_d = timeout_flag_q | (state_d == BERR);
  end

  always_ff @(posedge cpuClock or negedge npdsReset) begin
    if (!npdsReset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      c8m_prev_q     <= 1'b1;
      npds_as_q      <= 1'b1;
      cycle_active_q <= 1'b0;
      dsack_req_q    <= 1'b0;
      vpa_cycle_q    <= 1'b0;
      berr_req_q     <= 1'b0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      c8m_prev_q     <= c8m_prev_d;
      npds_as_q      <= npds_as_d;
      cycle_active_q <= cycle_active_d;
      dsack_req_q    <= dsack_req_d;
      vpa_cycle_q    <= vpa_cycle_d;
      berr_req_q     <= berr_req_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign bus.npdsAs      = npds_as_q;
  assign bus.cycleActive = cycle_active_q;
  assign bus.dsackReq    = dsack_req_q;
  assign bus.vpaCycle    = vpa_cycle_q;
  assign bus.berrReq     = berr_req_q;
  assign bus.timeoutFlag = timeout_flag_q;

endmodule
